seq_divider: RTL and testbench

- Multi-cycle restoring integer divider for the execution stage.
- Sits directly downstream of the two's-complement negation stage. Signed operands are converted to magnitudes with the N-bit two's-complement negation (invert + 1) before iterating.
- The same negation is applied again to the quotient and remainder signs after iterating.
- Produces RISC-V DIV/DIVU/REM/REMU results with a start/busy/done handshake.

---
 rtl/seq_divider.sv | 230 +++++++++++++++++++++++
 tb/tb_seq_divider.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring integer divider (RISC-V DIV/DIVU/REM/REMU)
//               with a start/busy/done handshake. Signed operands are turned
//               into magnitudes by two's-complement negation, one quotient bit
//               is produced per cycle (MSB first), and the signs are restored
//               afterwards.
// Optional    : SEQ_DIVIDER_EARLY_EXIT_EN - when defined, an operation whose
//               dividend magnitude is below the divisor magnitude skips the
//               iteration and finishes with the divide-by-zero latency.
// Ports       : clk, rst (async, active-high)
//               start, is_signed, dividend[N], divisor[N] - request, sampled
//                                                           only while idle
//               busy, done (1-cycle pulse)                  - handshake
//               quotient[N], remainder[N], div_by_zero      - held results
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // r_dvd holds the raw dividend until PREP, its magnitude afterwards, and
    // gradually turns into the unsigned quotient during ITER.
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dsr;
    logic [N-1:0]  r_orig;
    logic [N-1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_is_signed;
    logic          r_q_neg;
    logic          r_r_neg;
    logic          r_zero;
    logic          r_early;
    logic [N-1:0]  r_quot_out;
    logic [N-1:0]  r_rem_out;
    logic          r_dbz_out;

    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dsr_mag;
    logic          w_dsr_zero;
    logic          w_early;
    logic [N:0]    w_shift;
    logic          w_ge;
    logic [N-1:0]  w_diff;
    logic [N-1:0]  w_dvd_sh;

    function automatic logic [N-1:0] f_neg(input logic [N-1:0] x);
        return ~x + {{(N-1){1'b0}}, 1'b1};
    endfunction

    // ------------------------------------------------------------------------
    // Magnitudes of the latched operands (valid while in PREP)
    // ------------------------------------------------------------------------
    assign w_dvd_mag  = (r_is_signed & r_dvd[N-1]) ? f_neg(r_dvd) : r_dvd;
    assign w_dsr_mag  = (r_is_signed & r_dsr[N-1]) ? f_neg(r_dsr) : r_dsr;
    assign w_dsr_zero = (r_dsr == '0);

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign w_early = ~w_dsr_zero & (w_dvd_mag < w_dsr_mag);
`else
    assign w_early = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // One restoring step. The shifted partial remainder needs N+1 bits; when
    // its top bit is set it certainly exceeds the divisor, and the true
    // difference always fits in N bits, so an N-bit subtract is sufficient.
    // ------------------------------------------------------------------------
    assign w_shift  = {r_rem, r_dvd[N-1]};
    assign w_ge     = w_shift[N] | (w_shift[N-1:0] >= r_dsr);
    assign w_diff   = w_shift[N-1:0] - r_dsr;
    assign w_dvd_sh = {r_dvd[N-2:0], 1'b0};

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = PREP;
                end
            end
            PREP: begin
                busy = 1'b1;
                // Zero divisor and early exit bypass ITER; FIX then loads the
                // special result, giving the two-edge latency for both.
                if (w_dsr_zero || w_early) begin
                    w_next = FIX;
                end else begin
                    w_next = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_orig      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_is_signed <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_zero      <= 1'b0;
            r_early     <= 1'b0;
            r_quot_out  <= '0;
            r_rem_out   <= '0;
            r_dbz_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd       <= dividend;
                        r_dsr       <= divisor;
                        r_orig      <= dividend;
                        r_is_signed <= is_signed;
                    end
                end
                PREP: begin
                    r_dvd   <= w_dvd_mag;
                    r_dsr   <= w_dsr_mag;
                    r_q_neg <= r_is_signed & (r_dvd[N-1] ^ r_dsr[N-1]);
                    r_r_neg <= r_is_signed & r_dvd[N-1];
                    r_rem   <= '0;
                    r_cnt   <= CW'(N);
                    r_zero  <= w_dsr_zero;
                    r_early <= w_early;
                end
                ITER: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_ge) begin
                        r_rem <= w_diff;
                        r_dvd <= w_dvd_sh | {{(N-1){1'b0}}, 1'b1};
                    end else begin
                        r_rem <= w_shift[N-1:0];
                        r_dvd <= w_dvd_sh;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        r_quot_out <= '1;
                        r_rem_out  <= r_orig;
                        r_dbz_out  <= 1'b1;
                    end else if (r_early) begin
                        r_quot_out <= '0;
                        r_rem_out  <= r_orig;
                        r_dbz_out  <= 1'b0;
                    end else begin
                        // Most-negative / -1 needs no special case: the
                        // magnitude quotient 2^(N-1) is already the answer.
                        r_quot_out <= r_q_neg ? f_neg(r_dvd) : r_dvd;
                        r_rem_out  <= r_r_neg ? f_neg(r_rem) : r_rem;
                        r_dbz_out  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quot_out;
    assign remainder   = r_rem_out;
    assign div_by_zero = r_dbz_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (N = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 32;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int tests;
    int fails;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a request for one edge, then wait for done. Returns the number of
    // edges after the accepting edge until done is seen, and the number of
    // sampled cycles with busy high.
    task automatic launch(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busyc);
        edges = 0;
        busyc = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busyc++;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL timeout: done never seen after %0d edges", edges);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] eq,
                          input logic [N-1:0] er, input logic edz, input int elat);
        int edges;
        int busyc;
        launch(sgn, a, b);
        wait_done(edges, busyc);
        chk({tag, "_lat"}, N'(edges), N'(elat));
        chk({tag, "_q"},   quotient, eq);
        chk({tag, "_r"},   remainder, er);
        chk({tag, "_dz"},  N'(div_by_zero), N'(edz));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, N'(done), '0);
    endtask

    initial begin
        int edges;
        int busyc;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", N'(busy), '0);
        chk("rst_done", N'(done), '0);
        chk("rst_q",    quotient, '0);
        chk("rst_r",    remainder, '0);
        chk("rst_dz",   N'(div_by_zero), '0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 100/7 with busy-length check
        launch(1'b0, 32'd100, 32'd7);
        wait_done(edges, busyc);
        chk("u100_7_lat",  N'(edges), N'(34));
        chk("u100_7_busy", N'(busyc), N'(34));
        chk("u100_7_q",    quotient, 32'h0000000E);
        chk("u100_7_r",    remainder, 32'h00000002);
        chk("u100_7_dz",   N'(div_by_zero), '0);
        // start raised during the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_start_busy", N'(busy), '0);
        @(posedge clk);
        #1;
        chk("done_start_busy2", N'(busy), '0);
        chk("u100_7_hold_q", quotient, 32'h0000000E);

        run_op("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        run_op("s_100_m7", 1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0, 34);
        run_op("u5_0",     1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 1'b1, 2);
        run_op("s5_0",     1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 1'b1, 2);
        run_op("s_m7_0",   1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2);
        run_op("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34);
        run_op("u_big",    1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 34);
        run_op("u3_10",    1'b0, 32'd3,        32'd10,       32'h00000000, 32'h00000003, 1'b0, EARLY_LAT);

        // 1000/3 with an ignored request for 9/2 in the middle
        launch(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges, busyc);
        chk("ign_lat", N'(edges + 10), N'(34));
        chk("ign_q",   quotient, 32'd333);
        chk("ign_r",   remainder, 32'd1);

        // Reset in the middle of a new operation
        @(posedge clk);
        launch(1'b0, 32'd1000, 32'd3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", N'(busy), '0);
        chk("mrst_done", N'(done), '0);
        chk("mrst_q",    quotient, '0);
        chk("mrst_r",    remainder, '0);
        chk("mrst_dz",   N'(div_by_zero), '0);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) edges++;
        end
        chk("mrst_nodone", N'(edges), '0);
        run_op("post9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
